execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
Execute pipeline stage. It sits directly downstream of the Decode stage register and consumes its E-suffixed control and data outputs. It computes the ALU result, resolves branches and jumps back to fetch, and runs a fixed-latency multi-cycle multiply that stalls upstream. It holds the Execute/Memory pipeline register that feeds the Memory stage.

Parameters:
MUL_CYCLES, 3, total cycles a multiply occupies Execute (legal range 1..8)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
FlushE  in  1  squash the current Execute instruction
RegWriteE  in  1  register write enable from Decode
MemWriteE  in  1  memory write enable
JumpE  in  1  unconditional jump
BranchE  in  2  00 none, 01 beq, 10 bne, 11 blt (signed)
ALUSrcE  in  1  0: SrcB=RD2E, 1: SrcB=ImmExtE
ResultSrcE  in  1  0: ALU result, 1: memory data (passed through)
ALUControlE  in  3  operation select
RD1E, RD2E, ImmExtE  in  19 each  operands and immediate
PCE  in  15  PC of the instruction in Execute
RDE  in  5  destination register
Cant_ByteE  in  1  byte/word select (passed through)
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  15  redirect target (combinational)
StallE  out  1  upstream must hold Decode/Execute state (combinational)
RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM  out  1 each  registered controls
ALUResultM  out  19  registered ALU or product result
WriteDataM  out  19  registered RD2E
RDM  out  5  registered destination

Behaviour:
- Reset, asynchronous: every M output is 0, FSM goes to IDLE, counter is 0. Combinational outputs follow their inputs.
- SrcB = ALUSrcE ? ImmExtE : RD2E. All arithmetic is 19-bit and wraps modulo 2^19.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 logical shr, 111 mul.
- Shift amount is SrcB[4:0]. An amount of 19 or more gives 0.
- mul produces the low 19 bits of RD1E*SrcB.
- Branch compare always uses RD1E vs RD2E:
  - beq: taken when equal.
  - bne: taken when not equal.
  - blt: taken when RD1E < RD2E, compared as signed two's complement.
- PCSrcE = JumpE | branch taken.
- PCTargetE = PCE + ImmExtE[14:0], modulo 2^15.
- PCSrcE is forced to 0 while FlushE = 1.
- Non-mul instruction: 1-cycle latency. At the next rising edge M captures RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, the ALU result, RD2E and RDE.
- Bubble: RegWriteM = MemWriteM = 0. The other M fields are don't-care; the implementation loads 0.
- Multiply FSM (states IDLE, BUSY; counter cnt):
  - IDLE, mul present, MUL_CYCLES = 1: behaves as a non-mul instruction, StallE = 0.
  - IDLE, mul present, MUL_CYCLES > 1: StallE = 1, M loads a bubble, FSM goes to BUSY with cnt = MUL_CYCLES-2.
  - BUSY, cnt != 0: StallE = 1, M loads a bubble, cnt decrements.
  - BUSY, cnt = 0: StallE = 0, M loads the product and controls, FSM returns to IDLE.
  - Net effect: a multiply raises StallE for exactly MUL_CYCLES-1 cycles, and its result reaches M at the edge that ends cycle MUL_CYCLES.
- While StallE = 1, upstream holds all E inputs stable. Behaviour under changing E inputs during a stall is undefined.
- Back-to-back muls: the second mul starts in IDLE on the cycle after the first completes. There are no idle gap cycles.
- FlushE = 1 has priority over everything except reset. M loads a bubble, the FSM returns to IDLE (an in-flight multiply is aborted), and StallE = 0.
- Reset asserted mid-multiply aborts it immediately. No partial result ever reaches M.

Test Plan:
- Reset, then release. All M outputs read 0, StallE = 0. Apply add RD1E=5, RD2E=7, ALUSrcE=0, RegWriteE=1, RDE=3 -> one edge later ALUResultM=12, RDM=3, RegWriteM=1.
- Wrap and shift cases:
  - RD1E=0x7FFFF plus ImmExtE=1 with ALUSrcE=1 -> ALUResultM=0.
  - shl with SrcB=20 -> 0.
  - shr of 0x40000 by 18 -> 1.
- Branch cases:
  - blt with RD1E=0x7FFFF (-1), RD2E=1, PCE=100, ImmExtE=0x7FFFC (-4) -> PCSrcE=1, PCTargetE=96.
  - Same with FlushE=1 -> PCSrcE=0.
- mul 300*400 with MUL_CYCLES=3 -> StallE high for 2 cycles, bubbles in M, then ALUResultM = 120000 mod 2^19 = 120000 with RegWriteM=1. A second mul presented immediately after also takes 3 cycles.
- Abort cases:
  - FlushE asserted in the second cycle of a multiply -> StallE drops the same cycle, M holds a bubble, the next add completes in 1 cycle.
  - Repeat with reset instead of FlushE -> M outputs are 0 asynchronously.
- Parameter cases:
  - MUL_CYCLES=1: mul 3*4 -> no stall, ALUResultM=12 after 1 edge.
  - MUL_CYCLES=8: StallE high for exactly 7 cycles.

Source files
------------

// File: rtl/execute_stage.sv
// Execute pipeline stage: ALU, branch/jump resolution, fixed-latency multiply
// with upstream stall, and the Execute/Memory pipeline register.
module execute_stage #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FlushE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic [1:0]  BranchE,
    input  logic        ALUSrcE,
    input  logic        ResultSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [18:0] RD1E,
    input  logic [18:0] RD2E,
    input  logic [18:0] ImmExtE,
    input  logic [14:0] PCE,
    input  logic [4:0]  RDE,
    input  logic        Cant_ByteE,
    output logic        PCSrcE,
    output logic [14:0] PCTargetE,
    output logic        StallE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic        Cant_ByteM,
    output logic [18:0] ALUResultM,
    output logic [18:0] WriteDataM,
    output logic [4:0]  RDM
);

    typedef enum logic {IDLE, BUSY} state_t;

    // First BUSY cycle count; only meaningful when the multiply spans more than one cycle.
    localparam logic [2:0] CNT_INIT = (MUL_CYCLES > 1) ? 3'(MUL_CYCLES - 2) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [18:0] srcB;
    logic [4:0]  shamt;
    logic [18:0] aluResult;
    logic        isMul;
    logic        branchTaken;
    logic        loadM;

    always_comb begin
        srcB      = ALUSrcE ? ImmExtE : RD2E;
        shamt     = srcB[4:0];
        aluResult = '0;
        case (ALUControlE)
            3'b000:  aluResult = RD1E + srcB;
            3'b001:  aluResult = RD1E - srcB;
            3'b010:  aluResult = RD1E & srcB;
            3'b011:  aluResult = RD1E | srcB;
            3'b100:  aluResult = RD1E ^ srcB;
            3'b101:  aluResult = (shamt >= 5'd19) ? '0 : (RD1E << shamt);
            3'b110:  aluResult = (shamt >= 5'd19) ? '0 : (RD1E >> shamt);
            default: aluResult = RD1E * srcB;
        endcase
    end

    assign isMul = (ALUControlE == 3'b111);

    always_comb begin
        branchTaken = 1'b0;
        case (BranchE)
            2'b01:   branchTaken = (RD1E == RD2E);
            2'b10:   branchTaken = (RD1E != RD2E);
            2'b11:   branchTaken = ($signed(RD1E) < $signed(RD2E));
            default: branchTaken = 1'b0;
        endcase
    end

    assign PCSrcE    = ~FlushE & (JumpE | branchTaken);
    assign PCTargetE = PCE + ImmExtE[14:0];

    // Flush wins over the multiply sequencer; otherwise a mul holds M at bubble until its last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallE  = 1'b0;
        loadM   = 1'b1;
        if (FlushE) begin
            state_d = IDLE;
            cnt_d   = '0;
            loadM   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (isMul && (MUL_CYCLES > 1)) begin
                        StallE  = 1'b1;
                        loadM   = 1'b0;
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt_q != 3'd0) begin
                        StallE = 1'b1;
                        loadM  = 1'b0;
                        cnt_d  = cnt_q - 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            Cant_ByteM <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RDM        <= '0;
        end else if (loadM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            Cant_ByteM <= Cant_ByteE;
            ALUResultM <= aluResult;
            WriteDataM <= RD2E;
            RDM        <= RDE;
        end else begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            Cant_ByteM <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RDM        <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: three instances (MUL_CYCLES 3, 1, 8) share
// one stimulus stream; each phase checks the instance it targets.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        FlushE, RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE;
    logic [1:0]  BranchE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE;
    logic [14:0] PCE;
    logic [4:0]  RDE;

    logic        PCSrcE3, StallE3, RegWriteM3, MemWriteM3, ResultSrcM3, Cant_ByteM3;
    logic [14:0] PCTargetE3;
    logic [18:0] ALUResultM3, WriteDataM3;
    logic [4:0]  RDM3;

    logic        PCSrcE1, StallE1, RegWriteM1, MemWriteM1, ResultSrcM1, Cant_ByteM1;
    logic [14:0] PCTargetE1;
    logic [18:0] ALUResultM1, WriteDataM1;
    logic [4:0]  RDM1;

    logic        PCSrcE8, StallE8, RegWriteM8, MemWriteM8, ResultSrcM8, Cant_ByteM8;
    logic [14:0] PCTargetE8;
    logic [18:0] ALUResultM8, WriteDataM8;
    logic [4:0]  RDM8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    execute_stage #(.MUL_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .RDE(RDE), .Cant_ByteE(Cant_ByteE), .PCSrcE(PCSrcE3), .PCTargetE(PCTargetE3),
        .StallE(StallE3), .RegWriteM(RegWriteM3), .MemWriteM(MemWriteM3),
        .ResultSrcM(ResultSrcM3), .Cant_ByteM(Cant_ByteM3), .ALUResultM(ALUResultM3),
        .WriteDataM(WriteDataM3), .RDM(RDM3)
    );

    execute_stage #(.MUL_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .RDE(RDE), .Cant_ByteE(Cant_ByteE), .PCSrcE(PCSrcE1), .PCTargetE(PCTargetE1),
        .StallE(StallE1), .RegWriteM(RegWriteM1), .MemWriteM(MemWriteM1),
        .ResultSrcM(ResultSrcM1), .Cant_ByteM(Cant_ByteM1), .ALUResultM(ALUResultM1),
        .WriteDataM(WriteDataM1), .RDM(RDM1)
    );

    execute_stage #(.MUL_CYCLES(8)) u8 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .RDE(RDE), .Cant_ByteE(Cant_ByteE), .PCSrcE(PCSrcE8), .PCTargetE(PCTargetE8),
        .StallE(StallE8), .RegWriteM(RegWriteM8), .MemWriteM(MemWriteM8),
        .ResultSrcM(ResultSrcM8), .Cant_ByteM(Cant_ByteM8), .ALUResultM(ALUResultM8),
        .WriteDataM(WriteDataM8), .RDM(RDM8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ctl, input logic [18:0] rd1, input logic [18:0] rd2,
                                 input logic [18:0] imm, input logic aluSrc, input logic regWrite,
                                 input logic [4:0] rd);
        ALUControlE = ctl;
        RD1E        = rd1;
        RD2E        = rd2;
        ImmExtE     = imm;
        ALUSrcE     = aluSrc;
        RegWriteE   = regWrite;
        RDE         = rd;
        FlushE      = 1'b0;
        MemWriteE   = 1'b0;
        JumpE       = 1'b0;
        BranchE     = 2'b00;
        ResultSrcE  = 1'b0;
        Cant_ByteE  = 1'b0;
        PCE         = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        reset = 1'b1;
        applyStimulus(3'b000, 19'd0, 19'd0, 19'd0, 1'b0, 1'b0, 5'd0);
        #1;
        checkOutput("reset_ALUResultM", 32'(ALUResultM3), 32'd0);
        checkOutput("reset_RegWriteM", 32'(RegWriteM3), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset_RDM", 32'(RDM3), 32'd0);
        checkOutput("reset_StallE", 32'(StallE3), 32'd0);

        applyStimulus(3'b000, 19'd5, 19'd7, 19'd0, 1'b0, 1'b1, 5'd3);
        MemWriteE = 1'b1; ResultSrcE = 1'b1; Cant_ByteE = 1'b1;
        step();
        checkOutput("add_ALUResultM", 32'(ALUResultM3), 32'd12);
        checkOutput("add_RDM", 32'(RDM3), 32'd3);
        checkOutput("add_RegWriteM", 32'(RegWriteM3), 32'd1);
        checkOutput("add_WriteDataM", 32'(WriteDataM3), 32'd7);
        checkOutput("add_MemWriteM", 32'(MemWriteM3), 32'd1);
        checkOutput("add_ResultSrcM", 32'(ResultSrcM3), 32'd1);
        checkOutput("add_Cant_ByteM", 32'(Cant_ByteM3), 32'd1);

        applyStimulus(3'b000, 19'h7FFFF, 19'd9, 19'd1, 1'b1, 1'b1, 5'd1);
        step();
        checkOutput("add_wrap", 32'(ALUResultM3), 32'd0);
        applyStimulus(3'b001, 19'd5, 19'd7, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("sub_wrap", 32'(ALUResultM3), 32'h7FFFE);
        applyStimulus(3'b010, 19'h0F0F0, 19'h0FF00, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("and", 32'(ALUResultM3), 32'h0F000);
        applyStimulus(3'b011, 19'h0F0F0, 19'h0FF00, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("or", 32'(ALUResultM3), 32'h0FFF0);
        applyStimulus(3'b100, 19'h0F0F0, 19'h0FF00, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("xor", 32'(ALUResultM3), 32'h00FF0);
        applyStimulus(3'b101, 19'd1, 19'd4, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("shl_4", 32'(ALUResultM3), 32'd16);
        applyStimulus(3'b101, 19'd1, 19'd20, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("shl_20", 32'(ALUResultM3), 32'd0);
        applyStimulus(3'b110, 19'h40000, 19'd18, 19'd0, 1'b0, 1'b1, 5'd1);
        step();
        checkOutput("shr_18", 32'(ALUResultM3), 32'd1);
        applyStimulus(3'b110, 19'h40000, 19'd0, 19'd19, 1'b1, 1'b1, 5'd1);
        step();
        checkOutput("shr_19_imm", 32'(ALUResultM3), 32'd0);

        applyStimulus(3'b000, 19'h7FFFF, 19'd1, 19'h7FFFC, 1'b0, 1'b1, 5'd1);
        BranchE = 2'b11; PCE = 15'd100;
        #1;
        checkOutput("blt_taken", 32'(PCSrcE3), 32'd1);
        checkOutput("blt_target", 32'(PCTargetE3), 32'd96);
        FlushE = 1'b1;
        #1;
        checkOutput("blt_flushed", 32'(PCSrcE3), 32'd0);
        step();
        checkOutput("flush_bubble", 32'(RegWriteM3), 32'd0);
        FlushE = 1'b0; RD1E = 19'd1; RD2E = 19'h7FFFF;
        #1;
        checkOutput("blt_not_taken", 32'(PCSrcE3), 32'd0);
        BranchE = 2'b01; RD1E = 19'd5; RD2E = 19'd5;
        #1;
        checkOutput("beq_taken", 32'(PCSrcE3), 32'd1);
        BranchE = 2'b10;
        #1;
        checkOutput("bne_not_taken", 32'(PCSrcE3), 32'd0);
        BranchE = 2'b00; JumpE = 1'b1;
        #1;
        checkOutput("jump", 32'(PCSrcE3), 32'd1);

        applyStimulus(3'b111, 19'd300, 19'd400, 19'd0, 1'b0, 1'b1, 5'd9);
        #1;
        checkOutput("mul_stall_c1", 32'(StallE3), 32'd1);
        step();
        checkOutput("mul_bubble_c1", 32'(RegWriteM3), 32'd0);
        checkOutput("mul_stall_c2", 32'(StallE3), 32'd1);
        step();
        checkOutput("mul_bubble_c2", 32'(RegWriteM3), 32'd0);
        checkOutput("mul_stall_c3", 32'(StallE3), 32'd0);
        step();
        checkOutput("mul_result", 32'(ALUResultM3), 32'd120000);
        checkOutput("mul_RegWriteM", 32'(RegWriteM3), 32'd1);
        checkOutput("mul_RDM", 32'(RDM3), 32'd9);
        RD1E = 19'd1000; RD2E = 19'd1000;
        #1;
        stalls = 0;
        while (StallE3 && stalls < 20) begin
            step();
            stalls++;
        end
        checkOutput("mul2_stall_cycles", 32'(stalls), 32'd2);
        step();
        checkOutput("mul2_result", 32'(ALUResultM3), 32'd475712);

        applyStimulus(3'b111, 19'd6, 19'd7, 19'd0, 1'b0, 1'b1, 5'd2);
        step();
        FlushE = 1'b1;
        #1;
        checkOutput("flush_abort_stall", 32'(StallE3), 32'd0);
        step();
        checkOutput("flush_abort_bubble", 32'(RegWriteM3), 32'd0);
        applyStimulus(3'b000, 19'd2, 19'd3, 19'd0, 1'b0, 1'b1, 5'd4);
        #1;
        checkOutput("post_flush_stall", 32'(StallE3), 32'd0);
        step();
        checkOutput("post_flush_add", 32'(ALUResultM3), 32'd5);
        checkOutput("post_flush_RegWriteM", 32'(RegWriteM3), 32'd1);

        reset = 1'b1;
        #1;
        checkOutput("async_reset_ALUResultM", 32'(ALUResultM3), 32'd0);
        checkOutput("async_reset_RDM", 32'(RDM3), 32'd0);
        step();
        reset = 1'b0;
        applyStimulus(3'b111, 19'd6, 19'd7, 19'd0, 1'b0, 1'b1, 5'd2);
        step();
        reset = 1'b1;
        #1;
        checkOutput("reset_abort_RegWriteM", 32'(RegWriteM3), 32'd0);
        step();
        reset = 1'b0;
        applyStimulus(3'b000, 19'd10, 19'd20, 19'd0, 1'b0, 1'b1, 5'd5);
        #1;
        checkOutput("post_reset_stall", 32'(StallE3), 32'd0);
        step();
        checkOutput("post_reset_add", 32'(ALUResultM3), 32'd30);

        applyStimulus(3'b111, 19'd3, 19'd4, 19'd0, 1'b0, 1'b1, 5'd2);
        #1;
        checkOutput("mul1_stall", 32'(StallE1), 32'd0);
        step();
        checkOutput("mul1_result", 32'(ALUResultM1), 32'd12);
        checkOutput("mul1_RegWriteM", 32'(RegWriteM1), 32'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        stalls = 0;
        while (StallE8 && stalls < 20) begin
            step();
            stalls++;
        end
        checkOutput("mul8_stall_cycles", 32'(stalls), 32'd7);
        step();
        checkOutput("mul8_result", 32'(ALUResultM8), 32'd12);
        checkOutput("mul8_RegWriteM", 32'(RegWriteM8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
